// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, writable instruction memory, IF/ID register.
// A jump redirect from EX reloads the PC and puts one bubble into IF/ID; stall freezes everything except memory writes.
module fetch_stage #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int IMEM_DEPTH  = 2**PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   PC_Select,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic                   imem_we,
  input  logic [PC_WIDTH-1:0]    imem_waddr,
  input  logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic [PC_WIDTH-1:0]    pc_IF,
  output logic [INSTR_WIDTH-1:0] instr_ID,
  output logic [PC_WIDTH-1:0]    pc_ID,
  output logic [1:0]             opcode_ID,
  output logic                   valid_ID,
  output logic [15:0]            fetch_count
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [INSTR_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [INSTR_WIDTH-1:0] fetch_word;

  // Program contents survive reset, so this memory has no reset branch.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Read happens before the write on the same edge takes effect: same-address fetch sees the old word.
  assign fetch_word = imem[pc_IF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_IF       <= '0;
      instr_ID    <= '0;
      pc_ID       <= '0;
      valid_ID    <= 1'b0;
      fetch_count <= '0;
    end else if (PC_Select) begin
      // Redirect wins over stall; the squashed slot becomes an all-zero bubble.
      pc_IF    <= jump_target;
      instr_ID <= '0;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
    end else if (!stall) begin
      pc_IF       <= pc_IF + PC_ONE;
      instr_ID    <= fetch_word;
      pc_ID       <= pc_IF;
      valid_ID    <= 1'b1;
      fetch_count <= fetch_count + 16'd1;
    end
  end

  assign opcode_ID = instr_ID[INSTR_WIDTH-1 -: 2];

endmodule
